sram_1r1w_param: RTL
====================

Name: sram_1r1w_param

Overview:
- Parametrised next-generation 1-read/1-write synchronous SRAM for the Bellman-Ford output and distance buffers.
- Generalises the fixed 16K x 16 buffer in width and depth.
- Adds per-lane write masks, a registered read pipeline with valid flag, write-first collision bypass, and a post-reset clear sequencer, so buffers start at a known value (e.g. infinity) without a software fill pass.

Parameters:
DATA_W  16  word width in bits; must be a multiple of LANE_W
LANE_W  8  bits per write-mask lane
ADDR_W  14  address width
DEPTH  16384  number of words; must be <= 2**ADDR_W
READ_LAT  1  read latency in cycles, 1 or 2
CLEAR_ON_RESET  1  1 = fill the whole array with CLEAR_VALUE after reset
CLEAR_VALUE  16'hFFFF  fill word; DATA_W bits wide

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
we  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_mask  in  DATA_W/LANE_W  per-lane write enable; bit k covers bits [k*LANE_W +: LANE_W]
wr_data  in  DATA_W  write data
re  in  1  read request
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data carries the result of a request issued READ_LAT cycles earlier
init_busy  out  1  clear sequence in progress; user ports ignored
collision  out  1  rd_valid companion; read address equalled an active write address on the request cycle

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are named clock and reset_n.

Reset (reset_n low):
- rd_data=0, rd_valid=0, collision=0, read pipeline flushed.
- init_busy=1 if CLEAR_ON_RESET, else 0.
- The array itself is not reset.

Clear FSM, states CLEAR and READY:
- After reset release: state = CLEAR if CLEAR_ON_RESET, else READY.
- CLEAR writes CLEAR_VALUE (all lanes) to address clr_cnt each cycle, counting 0..DEPTH-1.
- After writing DEPTH-1, state goes to READY and init_busy drops. Total duration is exactly DEPTH cycles after the first rising edge with reset_n high.
- In CLEAR, we and re are ignored: no write, no rd_valid.
- reset_n asserted mid-clear restarts the clear at address 0.

Write (READY):
- On a rising edge with we=1 and wr_addr < DEPTH, each lane with wr_mask[k]=1 is updated; other lanes keep their value.
- we=1 with wr_mask=0 is a no-op.
- wr_addr >= DEPTH: write dropped silently.

Read (READY):
- re=1 sampled at edge N: rd_data and rd_valid=1 appear after edge N+READ_LAT-1 completes, i.e. visible in cycle N+READ_LAT relative to the request cycle.
- Back-to-back reads are fully pipelined, one result per cycle.
- rd_valid=0 cycles hold the previous rd_data.
- rd_addr >= DEPTH returns 0 with rd_valid=1.

Collision (same-edge read and write):
- Applies when re=1, we=1 and rd_addr==wr_addr.
- Write-first: returned word = new data on masked lanes, old data on unmasked lanes.
- collision=1 alongside that rd_valid.

Width:
- No arithmetic on data.
- Address compare is full ADDR_W bits.
- clr_cnt is ADDR_W+1 bits, so DEPTH = 2**ADDR_W terminates without wrap.

Decomposition:
- Package sram_pkg: state enum (CLEAR, READY), READ_LAT legal values, and the function lanes(DATA_W, LANE_W).
- Sub-module sram_clear_seq: FSM plus clr_cnt; outputs clr_we, clr_addr, init_busy.
- The top level muxes clr_* against the user write port and implements the array and the read pipeline.

Test Plan:
- Clear duration: DEPTH=16, CLEAR_ON_RESET=1, CLEAR_VALUE=16'hFFFF, release reset -> init_busy high for exactly 16 cycles; then reads of addresses 0..15 all return 16'hFFFF with rd_valid.
- Masked write: write 16'h1234 mask 2'b11 to address 5, then 16'hAB00 mask 2'b10 -> read of 5 returns 16'hAB34 after READ_LAT cycles.
- Collision: address 7 holds 16'h00FF; same-edge write 16'h5A5A mask 2'b01 and read of 7 -> rd_data=16'h005A, collision=1.
- Pipelining: READ_LAT=2, re high for 4 consecutive cycles on addresses 0..3 -> 4 consecutive rd_valid pulses, in order, starting 2 cycles after the first request.
- Reset mid-clear: assert reset_n low at clear cycle 8 of 16, release -> rd_valid drops, clear restarts at 0 and lasts 16 full cycles; we/re during clear have no effect.
- Out-of-range: DEPTH=12, ADDR_W=4, write to 13, read 13 -> rd_data=0 with rd_valid=1; addresses 0..11 unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1R1W SRAM.
// Imported by the clear sequencer and the top level.
package sram_pkg;

    typedef enum logic {
        CLEAR,
        READY
    } clr_state_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 2;

    function automatic int lanes(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Post-reset clear sequencer: walks every address once,
// then hands the write port back to the user.
module sram_clear_seq
    import sram_pkg::*;
#(
    parameter int ADDR_W         = 14,
    parameter int DEPTH          = 16384,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              init_busy
);

    localparam clr_state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
    // One extra bit so DEPTH == 2**ADDR_W still has a reachable last value
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    clr_state_t        state;
    clr_state_t        state_nxt;
    logic [ADDR_W:0]   clr_cnt;
    logic [ADDR_W:0]   cnt_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RST_STATE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = clr_cnt;
        unique case (state)
            CLEAR: begin
                if (clr_cnt == LAST) begin
                    state_nxt = READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = clr_cnt + 1'b1;
                end
            end
            READY: cnt_nxt = '0;
        endcase
    end

    assign clr_we    = (state == CLEAR);
    assign clr_addr  = clr_cnt[ADDR_W-1:0];
    assign init_busy = (state == CLEAR);

endmodule

// File: rtl/sram_1r1w_param.sv
// Parametrised 1R1W synchronous SRAM with lane masks, write-first
// bypass, registered read pipeline and post-reset clear.
module sram_1r1w_param
    import sram_pkg::*;
#(
    parameter int              DATA_W         = 16,
    parameter int              LANE_W         = 8,
    parameter int              ADDR_W         = 14,
    parameter int              DEPTH          = 16384,
    parameter int              READ_LAT       = 1,
    parameter int              CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = 16'hFFFF
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W/LANE_W-1:0]   wr_mask,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       re,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       init_busy,
    output logic                       collision
);

    localparam int NL  = lanes(DATA_W, LANE_W);
    localparam int LAT = (READ_LAT >= LAT_MAX) ? LAT_MAX : LAT_MIN;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    sram_clear_seq #(
        .ADDR_W         (ADDR_W),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clock     (clock),
        .reset_n   (reset_n),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_busy (init_busy)
    );

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_ok;
    logic              rd_ok;
    logic              rd_req;
    logic              hit;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [NL-1:0]     w_mask;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] rd_word;

    assign wr_ok  = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_ok  = ({1'b0, rd_addr} < DEPTH_X);
    assign rd_req = re && !init_busy;
    assign hit    = we && (rd_addr == wr_addr);

    always_comb begin
        if (init_busy) begin
            w_en   = clr_we;
            w_addr = clr_addr;
            w_mask = '1;
            w_data = CLEAR_VALUE;
        end else begin
            w_en   = we && wr_ok;
            w_addr = wr_addr;
            w_mask = wr_mask;
            w_data = wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && w_en) begin
            for (int k = 0; k < NL; k++) begin
                if (w_mask[k]) begin
                    mem[w_addr][k*LANE_W +: LANE_W] <= w_data[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Write-first: masked lanes of a same-edge write override the array
    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = mem[rd_addr];
            for (int k = 0; k < NL; k++) begin
                if (hit && wr_mask[k]) begin
                    rd_word[k*LANE_W +: LANE_W] = wr_data[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    logic              a_valid;
    logic              a_coll;
    logic [DATA_W-1:0] a_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_valid <= 1'b0;
            a_coll  <= 1'b0;
            a_data  <= '0;
        end else begin
            a_valid <= rd_req;
            a_coll  <= rd_req && hit;
            if (rd_req) begin
                a_data <= rd_word;
            end
        end
    end

    generate
        if (LAT == 2) begin : g_lat2
            logic              b_valid;
            logic              b_coll;
            logic [DATA_W-1:0] b_data;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    b_valid <= 1'b0;
                    b_coll  <= 1'b0;
                    b_data  <= '0;
                end else begin
                    b_valid <= a_valid;
                    b_coll  <= a_coll;
                    if (a_valid) begin
                        b_data <= a_data;
                    end
                end
            end

            assign rd_valid  = b_valid;
            assign collision = b_coll;
            assign rd_data   = b_data;
        end else begin : g_lat1
            assign rd_valid  = a_valid;
            assign collision = a_coll;
            assign rd_data   = a_data;
        end
    endgenerate

endmodule
